// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the stopwatch core.
// Imported by stopwatch_lap and lap_fifo.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam int CNT_W_DEF     = 14;
  localparam int TICK_DIV_DEF  = 10;
  localparam int LAP_DEPTH_DEF = 4;
  localparam int WRAP_DEF      = 1;

endpackage

// File: rtl/lap_fifo.sv
// First-word-fall-through FIFO holding captured lap counts.
// Head reads as zero while empty so lap_data idles low.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF,
  parameter int DEPTH = LAP_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd;
  logic [AW-1:0]    wr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop)  rd <= nxt(rd);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Full with a same-cycle pop overwrites the slot being read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch with prescaler, wrap/saturate overflow and lap FIFO.
// Lap FIFO is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int LAP_DEPTH = LAP_DEPTH_DEF,
  parameter int WRAP      = WRAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             lap_ready,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             overflow,
  output logic             lap_valid,
  output logic [CNT_W-1:0] lap_data,
  output logic             lap_drop
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_n;
  logic [PW-1:0] presc;
  logic          run_go;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) state <= SW_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      clear:
        state_n = SW_IDLE;
      !clear && stop:
        if (state == SW_RUN) state_n = SW_PAUSE;
      !clear && !stop && start:
        state_n = SW_RUN;
      default: ;
    endcase
  end

  assign running = (state == SW_RUN);
  assign run_go  = running && !clear && !stop;
  assign tick    = run_go && (presc == PMAX);

  // Prescaler holds outside RUN so a resume keeps its phase.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (run_go) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (count == '1) begin
          overflow <= 1'b1;
          if (WRAP != 0) count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic push;
  logic full;
  logic empty;

  assign push      = lap && !clear && (state != SW_IDLE);
  assign lap_valid = !empty;

  lap_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .din   (count),
    .pop   (lap_ready),
    .dout  (lap_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) lap_drop <= 1'b0;
    else lap_drop <= push && full && !lap_ready;
  end
`else
  wire unused_lap = &{1'b0, lap, lap_ready};

  assign lap_valid = 1'b0;
  assign lap_data  = '0;
  assign lap_drop  = 1'b0;
`endif

endmodule
